// File: rtl/booth_r4_mul_seq.sv
// booth_r4_mul_seq
//   Sequential radix-4 Booth multiplier. Each CALC cycle retires one Booth digit
//   into an internal accumulator, and the full 2*WIDTH-bit product is
//   registered on completion. Signed or unsigned operation is chosen per request.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   start          request, accepted in IDLE or DONE only
//   flush          synchronous abort; has priority over start
//   signed_mode    1 = two's complement operands, 0 = unsigned (latched at accept)
//   multiplicand   operand A (latched at accept)
//   multiplicator  operand B (latched at accept)
//   busy           high while in CALC
//   done           one-cycle pulse; product valid
//   product        result register, changes only on completion or reset
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start
// CALC   | one Booth digit per cycle, cnt = digit index
// DONE   | done pulse; start here chains the next operation with no gap

module booth_r4_mul_seq #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               flush,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplicator,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int ITER  = WIDTH / 2 + 1;
   localparam int ACC_W = 2 * WIDTH + 4;
   // extended multiplier plus the implicit y[-1] = 0 below bit 0
   localparam int Y_W   = WIDTH + 3;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [ACC_W-1:0]   a_sh;
   logic [ACC_W-1:0]   acc;
   logic [Y_W-1:0]     y_sh;

   logic               pp_zero;
   logic               pp_two;
   logic               pp_neg;
   logic [ACC_W-1:0]   pp_mag;
   logic [ACC_W-1:0]   pp_term;
   logic [ACC_W-1:0]   acc_next;
   logic [ACC_W-1:0]   a_ext;
   logic [Y_W-1:0]     y_init;

   // Both operands are taken as (WIDTH+2)-bit signed values. Zero extension
   // in unsigned mode keeps the top Booth digit non-negative, so one datapath
   // gives exact results in both modes, including the most-negative inputs.
   always_comb begin
      a_ext  = {{(ACC_W - WIDTH){signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
      y_init = {{2{signed_mode & multiplicator[WIDTH-1]}}, multiplicator, 1'b0};
   end

   // a_sh already carries the 4^i weight of the current digit, so the
   // partial product only has to pick 0, A or 2A and a sign.
   always_comb begin
      pp_zero = 1'b0;
      pp_two  = 1'b0;
      pp_neg  = 1'b0;
      case (y_sh[2:0])
         3'b000, 3'b111: pp_zero = 1'b1;
         3'b001, 3'b010: pp_two  = 1'b0;
         3'b011:         pp_two  = 1'b1;
         3'b100: begin
            pp_two = 1'b1;
            pp_neg = 1'b1;
         end
         3'b101, 3'b110: pp_neg  = 1'b1;
         default:        pp_zero = 1'b1;
      endcase

      pp_mag = pp_two ? {a_sh[ACC_W-2:0], 1'b0} : a_sh;

      // A negative digit adds the inverted magnitude, and the carry-in
      // completes the two's complement.
      if (pp_zero) begin
         pp_term = '0;
      end else if (pp_neg) begin
         pp_term = ~pp_mag;
      end else begin
         pp_term = pp_mag;
      end

      acc_next = acc + pp_term + ACC_W'(pp_neg & ~pp_zero);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         a_sh    <= '0;
         acc     <= '0;
         y_sh    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else if (flush) begin
         state <= S_IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= a_ext;
                  y_sh  <= y_init;
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_CALC;
               end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end

            S_CALC: begin
               acc  <= acc_next;
               a_sh <= {a_sh[ACC_W-3:0], 2'b00};
               y_sh <= {2'b00, y_sh[Y_W-1:2]};
               if (cnt == CNT_LAST) begin
                  product <= acc_next[2*WIDTH-1:0];
                  cnt     <= '0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_r4_mul_seq.sv
module tb_booth_r4_mul_seq;

   localparam int ITER16 = 9;
   localparam int ITER8  = 5;

   logic        clk = 1'b0;
   logic        rst;

   logic        start16, flush16, sm16;
   logic [15:0] a16, b16;
   logic        busy16, done16;
   logic [31:0] p16;

   logic        start8, flush8, sm8;
   logic [7:0]  a8, b8;
   logic        busy8, done8;
   logic [15:0] p8;

   booth_r4_mul_seq #(.WIDTH(16), .CNT_W(4)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .flush(flush16), .signed_mode(sm16),
      .multiplicand(a16), .multiplicator(b16), .busy(busy16), .done(done16), .product(p16)
   );

   booth_r4_mul_seq #(.WIDTH(8), .CNT_W(3)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .flush(flush8), .signed_mode(sm8),
      .multiplicand(a8), .multiplicator(b8), .busy(busy8), .done(done8), .product(p8)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] prod;
      int          when;
   } sb_t;

   typedef struct {
      bit          sm;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] exp;
   } vec_t;

   sb_t  q16[$];
   sb_t  q8[$];
   vec_t tbl[10];

   int n_vec = 0;
   int n_err = 0;

   function automatic logic [31:0] ref16(bit sm, logic [15:0] a, logic [15:0] b);
      longint p;
      if (sm) p = longint'($signed(a)) * longint'($signed(b));
      else    p = longint'(a) * longint'(b);
      return p[31:0];
   endfunction

   function automatic logic [15:0] ref8(bit sm, logic [7:0] a, logic [7:0] b);
      longint p;
      if (sm) p = longint'($signed(a)) * longint'($signed(b));
      else    p = longint'(a) * longint'(b);
      return p[15:0];
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic issue16(bit sm, logic [15:0] a, logic [15:0] b, logic [31:0] exp);
      sb_t e;
      @(negedge clk);
      sm16 = sm; a16 = a; b16 = b; start16 = 1'b1;
      e.prod = exp;
      e.when = cyc + 1 + ITER16;
      q16.push_back(e);
      @(negedge clk);
      start16 = 1'b0;
      a16 = 16'($urandom);
      b16 = 16'($urandom);
   endtask

   // Polls for done. Returns the number of busy cycles seen (including the
   // current one). With chain set, a new request is presented in the done
   // cycle so it is accepted straight out of DONE.
   task automatic wait_done16(input int bound, output int nbusy, input bit chain,
                              input bit csm, input logic [15:0] ca, input logic [15:0] cb,
                              input logic [31:0] cexp);
      sb_t e;
      bit  seen;
      seen  = 1'b0;
      nbusy = busy16 ? 1 : 0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         if (done16) begin
            seen = 1'b1;
            if (q16.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_done16: got done, expected none (cycle %0d)", cyc);
            end else begin
               e = q16.pop_front();
               check("product16", p16, e.prod);
               check("done_cycle16", cyc, e.when);
               check("busy_in_done16", busy16, 0);
            end
            if (chain) begin
               sm16 = csm; a16 = ca; b16 = cb; start16 = 1'b1;
               e.prod = cexp;
               e.when = cyc + 1 + ITER16;
               q16.push_back(e);
            end
         end else if (busy16) begin
            nbusy++;
         end
      end
      if (!seen) begin
         n_vec++; n_err++;
         $display("FAIL timeout16: got no done within %0d cycles, expected done", bound);
      end
   endtask

   task automatic op8(bit sm, logic [7:0] a, logic [7:0] b);
      sb_t e;
      bit  seen;
      @(negedge clk);
      sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
      e.prod = {16'h0, ref8(sm, a, b)};
      e.when = cyc + 1 + ITER8;
      q8.push_back(e);
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      seen = 1'b0;
      for (int i = 0; i < 15 && !seen; i++) begin
         @(negedge clk);
         if (done8) begin
            seen = 1'b1;
            e = q8.pop_front();
            check("product8", {16'h0, p8}, e.prod);
            check("done_cycle8", cyc, e.when);
         end
      end
      if (!seen) begin
         n_vec++; n_err++;
         $display("FAIL timeout8: got no done for a=%0h b=%0h, expected done", a, b);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          nb;
      int          ndone;
      logic [31:0] kept;
      logic [7:0]  corners[5];
      bit          s;
      logic [15:0] ra, rb;

      tbl[0] = '{1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1};
      tbl[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
      tbl[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};
      tbl[3] = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
      tbl[4] = '{1'b1, 16'h8000, 16'h7FFF, 32'hC0008000};
      tbl[5] = '{1'b0, 16'h8000, 16'h8000, 32'h40000000};
      tbl[6] = '{1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001};
      tbl[7] = '{1'b0, 16'hFFFF, 16'h0001, 32'h0000FFFF};
      tbl[8] = '{1'b1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF};
      tbl[9] = '{1'b0, 16'h1234, 16'h5678, 32'h06260060};

      rst = 1'b1;
      start16 = 1'b0; flush16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
      start8  = 1'b0; flush8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0;
      repeat (3) @(negedge clk);
      check("reset_busy16", busy16, 0);
      check("reset_done16", done16, 0);
      check("reset_product16", p16, 0);
      check("reset_product8", {16'h0, p8}, 0);
      rst = 1'b0;

      // table vectors
      foreach (tbl[i]) begin
         issue16(tbl[i].sm, tbl[i].a, tbl[i].b, tbl[i].exp);
         wait_done16(20, nb, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0);
         if (i == 0) check("busy_cycles16", nb, ITER16);
      end

      // random vectors against the model
      for (int i = 0; i < 20; i++) begin
         s  = 1'($urandom);
         ra = 16'($urandom);
         rb = 16'($urandom);
         issue16(s, ra, rb, ref16(s, ra, rb));
         wait_done16(20, nb, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0);
      end

      // start in CALC is ignored, then back-to-back accept out of DONE
      issue16(1'b1, 16'h1234, 16'hFEDC, ref16(1'b1, 16'h1234, 16'hFEDC));
      repeat (2) @(negedge clk);
      sm16 = 1'b0; a16 = 16'h5555; b16 = 16'h7777; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      wait_done16(20, nb, 1'b1, 1'b0, 16'hABCD, 16'h00EF, ref16(1'b0, 16'hABCD, 16'h00EF));
      @(negedge clk);
      start16 = 1'b0;
      check("no_idle_gap_busy16", busy16, 1);
      wait_done16(20, nb, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0);

      // async reset in CALC cycle 5
      issue16(1'b1, 16'h0F0F, 16'h3003, ref16(1'b1, 16'h0F0F, 16'h3003));
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_busy16", busy16, 0);
      check("rst_done16", done16, 0);
      check("rst_product16", p16, 0);
      void'(q16.pop_back());
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done16) ndone++;
      end
      check("rst_no_done16", ndone, 0);

      // flush in CALC cycle 4 keeps the previous product
      kept = ref16(1'b1, 16'h0123, 16'hFC40);
      issue16(1'b1, 16'h0123, 16'hFC40, kept);
      wait_done16(20, nb, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0);
      issue16(1'b0, 16'h7777, 16'h3333, ref16(1'b0, 16'h7777, 16'h3333));
      repeat (3) @(negedge clk);
      check("calc_product_stable16", p16, kept);
      flush16 = 1'b1;
      @(negedge clk);
      flush16 = 1'b0;
      check("flush_busy16", busy16, 0);
      void'(q16.pop_back());
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done16) ndone++;
      end
      check("flush_no_done16", ndone, 0);
      check("flush_product16", p16, kept);

      // flush together with start in IDLE: request dropped
      @(negedge clk);
      start16 = 1'b1; flush16 = 1'b1; a16 = 16'h0002; b16 = 16'h0003;
      @(negedge clk);
      start16 = 1'b0; flush16 = 1'b0;
      check("flush_start_busy16", busy16, 0);
      repeat (12) @(negedge clk);
      check("flush_start_product16", p16, kept);

      // WIDTH=8 instance: corner grid plus random pairs in both modes
      corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
      for (int m = 0; m < 2; m++)
         foreach (corners[i])
            foreach (corners[j])
               op8(1'(m), corners[i], corners[j]);
      for (int i = 0; i < 1000; i++)
         op8(1'($urandom), 8'($urandom), 8'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
